// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width default and alu_control codes for decode and execute
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_RSVD = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLL  = 3'b110,
    ALU_SRL  = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: result and zero flag from two operands
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [SHAMT_W-1:0] shamt;
  logic               a_lt_b;

  assign shamt  = b[SHAMT_W-1:0];
  assign a_lt_b = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    case (alu_op_e'(alu_control))
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, a_lt_b};
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_execute_stage.sv
// rtl/alu_execute_stage.sv - execute-stage operand select, ALU, branch decision and EX/MEM register
module alu_execute_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [2:0]      alu_control,
  input  logic            alu_src,
  input  logic            branch,
  input  logic            reg_write,
  input  logic            mem_write,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] pc,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd_out,
  output logic            reg_write_out,
  output logic            mem_write_out,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target
);

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic            alu_zero;

  assign op_b = alu_src ? imm_ext : rs2_data;

  alu_core #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_alu_core (
    .a           (rs1_data),
    .b           (op_b),
    .alu_control (alu_control),
    .result      (alu_res),
    .zero        (alu_zero)
  );

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic            zero_q, zero_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_write_q, mem_write_d;
  logic            branch_taken_q, branch_taken_d;
  logic [XLEN-1:0] branch_target_q, branch_target_d;

  // Flush loads like a normal cycle but forces a bubble, so it overrides stall.
  always_comb begin
    ex_valid_d      = ex_valid_q;
    alu_result_d    = alu_result_q;
    zero_d          = zero_q;
    store_data_d    = store_data_q;
    rd_d            = rd_q;
    reg_write_d     = reg_write_q;
    mem_write_d     = mem_write_q;
    branch_taken_d  = branch_taken_q;
    branch_target_d = branch_target_q;
    if (flush || !stall) begin
      ex_valid_d      = id_valid & ~flush;
      alu_result_d    = alu_res;
      zero_d          = alu_zero;
      store_data_d    = rs2_data;
      rd_d            = rd;
      reg_write_d     = id_valid & reg_write & ~flush;
      mem_write_d     = id_valid & mem_write & ~flush;
      branch_taken_d  = id_valid & branch & alu_zero & ~flush;
      branch_target_d = pc + imm_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      alu_result_q    <= '0;
      zero_q          <= 1'b0;
      store_data_q    <= '0;
      rd_q            <= '0;
      reg_write_q     <= 1'b0;
      mem_write_q     <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      alu_result_q    <= alu_result_d;
      zero_q          <= zero_d;
      store_data_q    <= store_data_d;
      rd_q            <= rd_d;
      reg_write_q     <= reg_write_d;
      mem_write_q     <= mem_write_d;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign alu_result    = alu_result_q;
  assign zero          = zero_q;
  assign store_data    = store_data_q;
  assign rd_out        = rd_q;
  assign reg_write_out = reg_write_q;
  assign mem_write_out = mem_write_q;
  assign branch_taken  = branch_taken_q;
  assign branch_target = branch_target_q;

endmodule

// File: tb/tb_alu_execute_stage.sv
// tb/tb_alu_execute_stage.sv - scoreboard bench for alu_execute_stage
module tb_alu_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, stall, flush;
  logic [2:0]  alu_control;
  logic        alu_src, branch, reg_write, mem_write;
  logic [4:0]  rd;
  logic [31:0] rs1_data, rs2_data, imm_ext, pc;
  logic        ex_valid, zero, reg_write_out, mem_write_out, branch_taken;
  logic [31:0] alu_result, store_data, branch_target;
  logic [4:0]  rd_out;

  always #5 clk = ~clk;

  alu_execute_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .stall         (stall),
    .flush         (flush),
    .alu_control   (alu_control),
    .alu_src       (alu_src),
    .branch        (branch),
    .reg_write     (reg_write),
    .mem_write     (mem_write),
    .rd            (rd),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .imm_ext       (imm_ext),
    .pc            (pc),
    .ex_valid      (ex_valid),
    .alu_result    (alu_result),
    .zero          (zero),
    .store_data    (store_data),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out),
    .mem_write_out (mem_write_out),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  typedef struct {
    logic        valid;
    logic [31:0] result;
    logic        zero;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic        bt;
    logic [31:0] tgt;
    logic        dc;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (op)
      3'b000: r = a + b;
      3'b001: r = a + ~b + 32'd1;
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b101: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      3'b110: for (int i = 0; i < 32; i++) r[i] = (i >= b[4:0]) ? a[i - b[4:0]] : 1'b0;
      3'b111: for (int i = 0; i < 32; i++) r[i] = (i + b[4:0] < 32) ? a[i + b[4:0]] : 1'b0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic issue(input logic v, input logic st, input logic fl, input logic [2:0] op,
                       input logic src, input logic br, input logic rw, input logic mw,
                       input logic [4:0] d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] p);
    exp_t        e;
    logic [31:0] r;
    id_valid = v; stall = st; flush = fl; alu_control = op; alu_src = src;
    branch = br; reg_write = rw; mem_write = mw; rd = d;
    rs1_data = a; rs2_data = b; imm_ext = imm; pc = p;
    if (!rst_n) begin
      e = '{1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};
    end else if (st && !fl) begin
      e = held;
    end else begin
      r = ref_alu(op, a, src ? imm : b);
      e.valid  = v && !fl;
      e.result = r;
      e.zero   = (r == 32'd0);
      e.store  = b;
      e.rd     = d;
      e.rw     = v && rw && !fl;
      e.mw     = v && mw && !fl;
      e.bt     = v && br && (r == 32'd0) && !fl;
      e.tgt    = p + imm;
      e.dc     = fl;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
    check("reg_write_out", {31'd0, reg_write_out}, {31'd0, e.rw});
    check("mem_write_out", {31'd0, mem_write_out}, {31'd0, e.mw});
    check("branch_taken", {31'd0, branch_taken}, {31'd0, e.bt});
    if (!e.dc) begin
      check("alu_result", alu_result, e.result);
      check("zero", {31'd0, zero}, {31'd0, e.zero});
      check("store_data", store_data, e.store);
      check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
      check("branch_target", branch_target, e.tgt);
    end
    held = e;
  endtask

  task automatic rand_issue(input logic st, input logic fl);
    issue($urandom_range(0, 1), st, fl, 3'($urandom_range(0, 7)), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; stall = 0; flush = 0; alu_control = 0; alu_src = 0;
    branch = 0; reg_write = 0; mem_write = 0; rd = 0;
    rs1_data = 0; rs2_data = 0; imm_ext = 0; pc = 0;
    held = '{1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0};

    rand_issue(1'b0, 1'b0);
    rand_issue(1'b0, 1'b0);
    rst_n = 1'b1;

    //     v  st fl op      src br rw mw rd    rs1           rs2           imm           pc
    issue(1, 0, 0, 3'b000, 0, 0, 1, 0, 5'd3, 32'd5,        32'd7,        32'd0,        32'h0);
    issue(1, 0, 0, 3'b000, 0, 0, 1, 0, 5'd4, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h4);
    issue(1, 0, 0, 3'b001, 0, 0, 1, 0, 5'd5, 32'd0,        32'd1,        32'd0,        32'h8);
    issue(1, 0, 0, 3'b101, 0, 0, 1, 0, 5'd6, 32'h80000000, 32'd1,        32'd0,        32'hC);
    issue(1, 0, 0, 3'b101, 0, 0, 1, 0, 5'd7, 32'd1,        32'h80000000, 32'd0,        32'h10);
    issue(1, 0, 0, 3'b110, 1, 0, 1, 0, 5'd8, 32'd1,        32'd0,        32'h21,       32'h14);
    issue(1, 0, 0, 3'b111, 0, 0, 1, 0, 5'd9, 32'h80000000, 32'd31,       32'd0,        32'h18);
    issue(1, 0, 0, 3'b100, 0, 0, 1, 1, 5'd1, 32'd123,      32'd456,      32'd0,        32'h1C);
    issue(1, 0, 0, 3'b001, 0, 1, 0, 0, 5'd0, 32'd9,        32'd9,        32'h20,       32'h100);
    issue(1, 0, 0, 3'b001, 0, 1, 0, 0, 5'd0, 32'd9,        32'd8,        32'h20,       32'h100);
    issue(1, 0, 0, 3'b010, 0, 0, 1, 1, 5'd10, 32'hF0,      32'h3C,       32'd0,        32'h104);
    for (int i = 0; i < 3; i++) rand_issue(1'b1, 1'b0);
    issue(1, 1, 1, 3'b011, 0, 0, 1, 1, 5'd11, 32'h1,       32'h2,        32'd0,        32'h108);
    issue(0, 0, 0, 3'b001, 0, 1, 1, 1, 5'd12, 32'd4,       32'd4,        32'd0,        32'h10C);
    issue(1, 0, 0, 3'b011, 0, 0, 1, 1, 5'd13, 32'hA0,      32'h05,       32'd0,        32'h110);
    rst_n = 1'b0;
    rand_issue(1'b1, 1'b0);
    rst_n = 1'b1;
    issue(1, 0, 0, 3'b000, 0, 0, 1, 0, 5'd14, 32'd20,      32'd22,       32'd0,        32'h200);
    for (int i = 0; i < 40; i++) rand_issue($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_execute_stage.md
# alu_execute_stage

Execute-stage datapath and EX/MEM pipeline register: consumes the 3-bit ALU control code produced by the decode-stage ALU decoder, selects operands, computes the ALU result, zero flag and branch decision, and registers them for the memory stage. It sits between the ID/EX boundary and the data-memory stage. It also owns stall and flush handling for the EX/MEM register.

## Interface
Parameters:
- XLEN, 32, datapath width; must be a power of two ≥ 8.
- SHAMT_W, $clog2(XLEN), shift-amount width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID/EX slot holds a real instruction.
- stall  in  1  hold the EX/MEM register contents.
- flush  in  1  load a bubble into EX/MEM.
- alu_control  in  3  operation code: 000 add, 001 sub, 010 and, 011 or, 101 slt, 110 sll, 111 srl, 100 reserved.
- alu_src  in  1  0: operand B = rs2_data; 1: operand B = imm_ext.
- branch  in  1  instruction is beq.
- reg_write  in  1  destination write enable.
- mem_write  in  1  store enable.
- rd  in  5  destination register index.
- rs1_data, rs2_data, imm_ext  in  XLEN  operands.
- pc  in  XLEN  PC of the instruction.
- ex_valid  out  1  EX/MEM slot valid.
- alu_result  out  XLEN  registered result.
- zero  out  1  registered (result == 0).
- store_data  out  XLEN  registered rs2_data.
- rd_out  out  5; reg_write_out  out  1; mem_write_out  out  1.
- branch_taken  out  1  registered branch decision.
- branch_target  out  XLEN  registered pc + imm_ext.

## Operation
- Operand A = rs1_data; operand B per alu_src.
- add/sub: modulo 2^XLEN, carries/overflow discarded.
- and/or: bitwise.
- slt: signed compare; result is 1 (zero-extended) if A < B, else 0.
- sll/srl: shift A by B[SHAMT_W-1:0]; srl is logical (zero-fill); upper bits of B ignored.
- 100 (reserved): result 0; zero = 1.
- zero = (combinational result == 0); branch_taken = id_valid & branch & zero.
- branch_target = pc + imm_ext, modulo 2^XLEN.
- Control outputs (reg_write_out, mem_write_out, branch_taken) are gated by id_valid; an invalid slot never writes or branches.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Register update priority each edge: reset > flush > stall > load.
- Reset (rst_n = 0 at edge): every output 0, including ex_valid, alu_result, zero, branch_target.
- flush = 1: ex_valid, reg_write_out, mem_write_out, branch_taken cleared. Data outputs load normally (don't-care). Flush wins over a simultaneous stall.
- stall = 1, flush = 0: all outputs hold; inputs ignored.
- Neither asserted: all outputs load from the current inputs.
- Reset asserted mid-stall: outputs go to 0 at that edge. The first load after reset release follows the normal load rule.
- No combinational path from any input to any output.

## Structure
- Shared package (alu_pkg): XLEN default; alu_control code constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL). The decode-stage ALU decoder must use the same constants.
- One sub-module: alu_core, purely combinational (a, b, alu_control → result, zero). The top level holds operand mux, branch logic and the EX/MEM register.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with random inputs -> all outputs 0. Release -> first valid add 5+7 gives alu_result = 12, ex_valid = 1 one cycle later.
- Arithmetic corners (XLEN = 32):
  - add 0xFFFFFFFF+1 -> 0, zero = 1.
  - sub 0-1 -> 0xFFFFFFFF.
  - slt 0x80000000 < 1 -> 1.
  - slt 1 < 0x80000000 -> 0.
- Shifts:
  - sll 1 by B = 0x00000021 -> 2 (only the low 5 bits are used).
  - srl 0x80000000 by 31 -> 1.
- Branch: branch = 1, sub with rs1 = rs2 = 9, pc = 0x100, imm = 0x20 -> branch_taken = 1, branch_target = 0x120. Same with rs2 = 8 -> branch_taken = 0.
- Stall/flush: load and (0xF0 & 0x3C = 0x30), then stall 3 cycles with changing inputs -> outputs hold at 0x30. Stall and flush together -> ex_valid = 0, reg_write_out = 0.
- Invalid slot: id_valid = 0, reg_write = 1, mem_write = 1, branch = 1 with equal operands -> reg_write_out = mem_write_out = branch_taken = 0, ex_valid = 0.
